// File: rtl/destroyable_block_array.sv
// destroyable_block_array
//
// Manages NUM_BLOCKS static, square, destructible level blocks. Each block
// keeps its hit points, a post-hit immunity window and a respawn timer. The
// blade hitbox is tested against every block each tick. When more than one
// block qualifies, only the lowest-index block takes the hit.
//
// Ports
//   sim_clk         game tick clock; all state changes on its rising edge
//   reset           synchronous, active-high; overrides every other event
//   bladePos        {x[19:10], y[9:0]}, the blade top-left corner
//   bladeActive     blade in flight; no hits are taken while low
//   blockPos        {x,y} per block (block i at [20i+19:20i]); constant INIT_POS
//   blockVisible    one bit per block, 1 = drawn (VISIBLE or COOLDOWN)
//   bladeHit        one-tick pulse, registered on the edge that took the hit
//   hitIndex        index of the struck block, meaningful while bladeHit=1
//   destroyedCount  running total of destroyed blocks, saturates at 255
//
// Per-block state
//   state        | meaning
//   ST_VISIBLE   | drawn and collidable
//   ST_COOLDOWN  | drawn, ignores hits until its timer reaches zero
//   ST_DESTROYED | hidden and not collidable until its timer reaches zero
//
// Both timers count down and are loaded with (ticks-1). The block leaves the
// timed state on the edge that follows terminal count, so the window lasts
// exactly HIT_COOLDOWN or RESPAWN_TICKS ticks. Hits are decided from the
// registered state. A block that returns to VISIBLE on an edge therefore
// cannot be struck on that same edge.
module destroyable_block_array #(
  parameter int NUM_BLOCKS    = 4,
  parameter int BLOCK_SIZE    = 32,
  parameter int BLADE_SIZE    = 16,
  parameter int HIT_POINTS    = 2,
  parameter int HIT_COOLDOWN  = 8,
  parameter int RESPAWN_TICKS = 600,
  parameter logic [20*NUM_BLOCKS-1:0] INIT_POS = {NUM_BLOCKS{10'd300, 10'd200}}
) (
  input  logic                    sim_clk,
  input  logic                    reset,
  input  logic [19:0]             bladePos,
  input  logic                    bladeActive,
  output logic [20*NUM_BLOCKS-1:0] blockPos,
  output logic [NUM_BLOCKS-1:0]   blockVisible,
  output logic                    bladeHit,
  output logic [3:0]              hitIndex,
  output logic [7:0]              destroyedCount
);

  localparam int MAX_TICKS = (HIT_COOLDOWN > RESPAWN_TICKS) ? HIT_COOLDOWN : RESPAWN_TICKS;
  localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [TIMER_W-1:0] COOL_LOAD    = TIMER_W'(HIT_COOLDOWN - 1);
  localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_TICKS - 1);
  localparam logic [2:0]         HP_FULL      = 3'(HIT_POINTS);
  localparam logic [10:0]        BLOCK_EXT    = 11'(BLOCK_SIZE);
  localparam logic [10:0]        BLADE_EXT    = 11'(BLADE_SIZE);

  typedef enum logic [1:0] {
    ST_VISIBLE   = 2'd0,
    ST_COOLDOWN  = 2'd1,
    ST_DESTROYED = 2'd2
  } blockState_t;

  blockState_t          state     [NUM_BLOCKS];
  blockState_t          stateNext [NUM_BLOCKS];
  logic [2:0]           hp        [NUM_BLOCKS];
  logic [2:0]           hpNext    [NUM_BLOCKS];
  logic [TIMER_W-1:0]   timer     [NUM_BLOCKS];
  logic [TIMER_W-1:0]   timerNext [NUM_BLOCKS];

  logic [NUM_BLOCKS-1:0] overlap;
  logic [NUM_BLOCKS-1:0] eligible;
  logic                  anyHit;
  logic [3:0]            hitSel;
  logic                  destroyEvent;

  logic                  bladeHitNext;
  logic [3:0]            hitIndexNext;
  logic [7:0]            destroyedCountNext;

  // Coordinates are widened to 11 bits so that x+size never wraps.
  function automatic logic boxOverlap(input logic [19:0] blade, input logic [19:0] blk);
    logic [10:0] bx, by, x, y;
    bx = {1'b0, blade[19:10]};
    by = {1'b0, blade[9:0]};
    x  = {1'b0, blk[19:10]};
    y  = {1'b0, blk[9:0]};
    return (bx < x + BLOCK_EXT) && (bx + BLADE_EXT > x) &&
           (by < y + BLOCK_EXT) && (by + BLADE_EXT > y);
  endfunction

  assign blockPos = INIT_POS;

  always_comb begin
    overlap      = '0;
    eligible     = '0;
    blockVisible = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      overlap[i]      = boxOverlap(bladePos, INIT_POS[20*i +: 20]);
      eligible[i]     = bladeActive && overlap[i] && (state[i] == ST_VISIBLE);
      blockVisible[i] = (state[i] != ST_DESTROYED);
    end
  end

  // Scan from the top index down so that the lowest eligible index is kept.
  always_comb begin
    anyHit = |eligible;
    hitSel = 4'd0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (eligible[i]) hitSel = 4'(i);
    end
  end

  always_comb begin
    destroyEvent = 1'b0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      stateNext[i] = state[i];
      hpNext[i]    = hp[i];
      timerNext[i] = timer[i];
      case (state[i])
        ST_VISIBLE: begin
          if (anyHit && (hitSel == 4'(i))) begin
            if (hp[i] > 3'd1) begin
              hpNext[i]    = hp[i] - 3'd1;
              stateNext[i] = ST_COOLDOWN;
              timerNext[i] = COOL_LOAD;
            end else begin
              stateNext[i] = ST_DESTROYED;
              timerNext[i] = RESPAWN_LOAD;
              destroyEvent = 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (timer[i] == '0) begin
            stateNext[i] = ST_VISIBLE;
          end else begin
            timerNext[i] = timer[i] - 1'b1;
          end
        end
        ST_DESTROYED: begin
          if (timer[i] == '0) begin
            stateNext[i] = ST_VISIBLE;
            hpNext[i]    = HP_FULL;
          end else begin
            timerNext[i] = timer[i] - 1'b1;
          end
        end
        default: begin
          stateNext[i] = ST_VISIBLE;
          hpNext[i]    = HP_FULL;
          timerNext[i] = '0;
        end
      endcase
    end

    bladeHitNext       = anyHit;
    hitIndexNext       = anyHit ? hitSel : 4'd0;
    destroyedCountNext = destroyedCount;
    if (destroyEvent && (destroyedCount != 8'hFF)) begin
      destroyedCountNext = destroyedCount + 8'd1;
    end
  end

  always_ff @(posedge sim_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        state[i] <= ST_VISIBLE;
        hp[i]    <= HP_FULL;
        timer[i] <= '0;
      end
      bladeHit       <= 1'b0;
      hitIndex       <= 4'd0;
      destroyedCount <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        state[i] <= stateNext[i];
        hp[i]    <= hpNext[i];
        timer[i] <= timerNext[i];
      end
      bladeHit       <= bladeHitNext;
      hitIndex       <= hitIndexNext;
      destroyedCount <= destroyedCountNext;
    end
  end

endmodule
